// File: rtl/next_kbd_responder_if.sv
// Purpose: upstream key/mouse word handshakes plus host-command status of the NeXT keyboard responder.
// Latency: none, this is only a signal bundle.
// Backpressure: kbd_ready/ms_ready are one-cycle consume pulses; a word stays pending until its pulse.
// Ports: kbd_valid/kbd_data/kbd_ready, ms_valid/ms_data/ms_ready, led/led_valid, host_reset, state.
// Modports: master = upstream translation logic side, slave = responder side.
interface next_kbd_responder_if;
    logic        kbd_valid;
    logic [15:0] kbd_data;
    logic        kbd_ready;
    logic        ms_valid;
    logic [15:0] ms_data;
    logic        ms_ready;
    logic [1:0]  led;
    logic        led_valid;
    logic        host_reset;
    logic [1:0]  state;

    modport master (
        output kbd_valid, kbd_data, ms_valid, ms_data,
        input  kbd_ready, ms_ready, led, led_valid, host_reset, state
    );

    modport slave (
        input  kbd_valid, kbd_data, ms_valid, ms_data,
        output kbd_ready, ms_ready, led, led_valid, host_reset, state
    );
endinterface

// File: rtl/next_kbd_responder.sv
// Purpose: device end of the NeXT keyboard/mouse link; decodes host frames, answers queries with 21-bit frames.
// Latency: response start edge TURN_CLKS after the 8th query-bit sample; each response bit held BIT_CLKS.
// Backpressure: none toward the host; upstream words are taken (ready pulse) only at response start.
// Ports: clk, rst_n (async active-low), from_host (async line in), to_host (line out), up (slave modport).
// Config: NEXT_KBD_MOUSE_EN defined -> mouse queries served from ms_valid/ms_data, else IDLE_MS_WORD.
module next_kbd_responder #(
    parameter int          BIT_CLKS      = 1431,
    parameter int          HALF_CLKS     = 715,
    parameter int          TURN_CLKS     = 2147,
    parameter logic [15:0] IDLE_KBD_WORD = 16'h0080,
    parameter logic [15:0] IDLE_MS_WORD  = 16'h0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        from_host,
    output logic                        to_host,
    next_kbd_responder_if.slave         up
);
    localparam int MAX_CLKS = (TURN_CLKS > BIT_CLKS) ? TURN_CLKS : BIT_CLKS;
    localparam int TMR_W    = $clog2(MAX_CLKS + 1);

    localparam logic [20:0] RESET_CMD   = 21'b111101111110000000000;
    // Ready frame stored b20..b0; shifted out from b0.
    localparam logic [20:0] READY_FRAME = {1'b1, 9'b0, 2'b11, 9'b0};

    typedef enum logic [2:0] {
        PH_IDLE, PH_HALF, PH_BITS, PH_TURN, PH_SEND, PH_REARM
    } phase_t;

    typedef enum logic [1:0] {
        LINK_UNINIT  = 2'd0,
        LINK_PENDING = 2'd1,
        LINK_ACTIVE  = 2'd2
    } link_t;

    logic [1:0]       sync_q;
    logic             fh_d;
    phase_t           phase;
    link_t            link;
    logic [TMR_W-1:0] tmr;
    logic [4:0]       bit_idx;
    logic [19:0]      rx_sr;
    logic [20:0]      tx_sr;
    logic             is_mouse;
    logic             kbd_ready_q;
    logic             ms_ready_q;
    logic [1:0]       led_q;
    logic             led_valid_q;
    logic             host_reset_q;

    logic             fh_s;
    logic             fall;
    logic [20:0]      rx_nxt;
    logic             kbd_take;
    logic             ms_take;
    logic [15:0]      word;
    logic [20:0]      data_frame;

    assign fh_s   = sync_q[1];
    assign fall   = fh_d & ~fh_s;
    // Newest sample lands in bit 0; after 8 samples [7:0] is the byte, after 21 the whole frame.
    assign rx_nxt = {rx_sr, fh_s};

    always_comb begin
        kbd_take = 1'b0;
        ms_take  = 1'b0;
        word     = IDLE_KBD_WORD;
        if (is_mouse) begin
`ifdef NEXT_KBD_MOUSE_EN
            ms_take = up.ms_valid;
            word    = up.ms_valid ? up.ms_data : IDLE_MS_WORD;
`else
            word    = IDLE_MS_WORD;
`endif
        end else begin
            kbd_take = up.kbd_valid;
            word     = up.kbd_valid ? up.kbd_data : IDLE_KBD_WORD;
        end
    end

`ifndef NEXT_KBD_MOUSE_EN
    // Mouse handshake inputs are deliberately left unconnected in this build.
    logic unused_ms;
    assign unused_ms = ^{up.ms_valid, up.ms_data};
`endif

    // b20..b0: 0, high byte, marker 010, low byte, 0.
    assign data_frame = {1'b0, word[15:8], 3'b010, word[7:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], from_host};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fh_d         <= 1'b1;
            phase        <= PH_IDLE;
            link         <= LINK_UNINIT;
            tmr          <= '0;
            bit_idx      <= '0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            is_mouse     <= 1'b0;
            to_host      <= 1'b1;
            kbd_ready_q  <= 1'b0;
            ms_ready_q   <= 1'b0;
            led_q        <= 2'b00;
            led_valid_q  <= 1'b0;
            host_reset_q <= 1'b0;
        end else begin
            fh_d         <= fh_s;
            kbd_ready_q  <= 1'b0;
            ms_ready_q   <= 1'b0;
            led_valid_q  <= 1'b0;
            host_reset_q <= 1'b0;
            tmr          <= tmr + 1'b1;
            case (phase)
                PH_IDLE: begin
                    if (fall) begin
                        phase <= PH_HALF;
                        tmr   <= TMR_W'(1);
                    end
                end
                PH_HALF: begin
                    if (tmr == TMR_W'(HALF_CLKS)) begin
                        if (fh_s) begin
                            phase <= PH_IDLE;       // line back high: glitch, not a start bit
                        end else begin
                            phase   <= PH_BITS;
                            tmr     <= TMR_W'(1);
                            bit_idx <= '0;
                        end
                    end
                end
                PH_BITS: begin
                    if (tmr == TMR_W'(BIT_CLKS)) begin
                        tmr   <= TMR_W'(1);
                        rx_sr <= rx_nxt[19:0];
                        if (bit_idx == 5'd7 && rx_nxt[6:0] == 7'b0001000) begin
                            if (link == LINK_UNINIT) begin
                                phase <= PH_IDLE;
                            end else begin
                                phase    <= PH_TURN;
                                is_mouse <= rx_nxt[7];
                            end
                        end else if (bit_idx == 5'd20) begin
                            phase <= PH_IDLE;
                            if (rx_nxt == RESET_CMD) begin
                                link         <= LINK_PENDING;
                                host_reset_q <= 1'b1;
                            end else if (rx_nxt[20:9] == 12'b000000001110 && rx_nxt[6:0] == 7'b0) begin
                                led_q       <= rx_nxt[8:7];
                                led_valid_q <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PH_TURN: begin
                    if (tmr == TMR_W'(TURN_CLKS)) begin
                        phase   <= PH_SEND;
                        tmr     <= TMR_W'(1);
                        bit_idx <= '0;
                        to_host <= 1'b0;            // start bit
                        if (link == LINK_PENDING) begin
                            tx_sr <= READY_FRAME;
                            link  <= LINK_ACTIVE;
                        end else begin
                            tx_sr       <= data_frame;
                            kbd_ready_q <= kbd_take;
                            ms_ready_q  <= ms_take;
                        end
                    end
                end
                PH_SEND: begin
                    if (tmr == TMR_W'(BIT_CLKS)) begin
                        tmr <= TMR_W'(1);
                        // bit_idx 0..20 drives b0..b20; 21 ends the frame.
                        if (bit_idx == 5'd21) begin
                            to_host <= 1'b1;
                            phase   <= PH_REARM;
                        end else begin
                            to_host <= tx_sr[0];
                            tx_sr   <= {1'b1, tx_sr[20:1]};
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PH_REARM: phase <= PH_IDLE;
                default:  phase <= PH_IDLE;
            endcase
        end
    end

    assign up.kbd_ready  = kbd_ready_q;
    assign up.ms_ready   = ms_ready_q;
    assign up.led        = led_q;
    assign up.led_valid  = led_valid_q;
    assign up.host_reset = host_reset_q;
    assign up.state      = link;
endmodule
